ac_frame_seq: RTL
=================

AC_FRAME_SEQ -- requirements
Module: ac_frame_seq

Interface
REQ-001 Parameters: N=32 sample width; NSAM=320 frame length; AW=9 address width; TMO=65535 run watchdog limit in cycles, 16-bit.
REQ-002 Clocking: one clock; reset is asynchronous and active-low.
REQ-003 Ports, clock and reset first:
  clk  in  1  system clock
  rst  in  1  async active-low reset
  start  in  1  frame request, sampled in IDLE only
  samp_valid  in  1  sample valid
  samp_data  in  N  Q16.16 windowed sample
  samp_ready  out  1  sample accept
  ram_addr  out  AW  Sn RAM address
  ram_wdata  out  N  Sn RAM write data
  ram_wren  out  1  Sn RAM write enable
  ac_addr  in  AW  autocorrelator read address (its sn_addr1)
  ac_rst_n  out  1  autocorrelator reset, active-low, registered
  startac  out  1  autocorrelator start
  doneac  in  1  autocorrelator done (sticky until its reset)
  busy  out  1  high in every state except IDLE
  done  out  1  one-cycle completion pulse
  err  out  1  watchdog error, sticky until next accepted start

Function
REQ-004 States: IDLE, LOAD, FLUSH, ENG_CLR, KICK, RUN, FIN.
REQ-005 IDLE: when start=1, go to LOAD, clear wcnt (AW bits) to 0, and clear err; start is ignored in all other states.
REQ-006 LOAD: samp_ready=1; on samp_valid&samp_ready, register ram_addr<=wcnt, ram_wdata<=samp_data, ram_wren<=1, and set wcnt<=wcnt+1; cycles without acceptance give ram_wren<=0.
REQ-007 LOAD exits to FLUSH on the cycle the sample with wcnt=NSAM-1 is accepted; samp_ready is 0 in every state except LOAD.
REQ-008 FLUSH: one cycle; ram_wren<=0 so the last write completes; then ENG_CLR.
REQ-009 ENG_CLR: ac_rst_n<=0 for exactly one cycle to clear the sticky doneac; then KICK.
REQ-010 KICK: startac<=1 for exactly one cycle; clear the 16-bit watchdog counter; then RUN.
REQ-011 RUN: ram_addr follows ac_addr combinationally with zero latency; ram_wren=0; the watchdog counter increments each cycle.
REQ-012 RUN exits to FIN when doneac=1; doneac is ignored in every other state.
REQ-013 RUN exits to IDLE with err<=1 and no done pulse when the watchdog reaches TMO before doneac.
REQ-014 If doneac and the watchdog limit occur in the same cycle, doneac wins: go to FIN, err stays 0.
REQ-015 FIN: done=1 for one cycle; then IDLE.
REQ-016 Outside RUN, ram_addr holds its last registered value.
REQ-017 Frame latency: NSAM accepted samples, +1 FLUSH, +1 ENG_CLR, +1 KICK, +engine cycles, +1 FIN.
REQ-018 Back-pressure: samp_valid low in LOAD stalls without limit; no timeout applies in LOAD.
REQ-019 ac_rst_n is 1 except in the ENG_CLR cycle and while rst=0, where ac_rst_n=0.

Reset
REQ-020 rst=0, at any time including mid-LOAD or mid-RUN, forces IDLE and sets: wcnt=0, watchdog=0, ram_addr=0, ram_wdata=0, ram_wren=0, samp_ready=0, startac=0, busy=0, done=0, err=0, ac_rst_n=0.
REQ-021 After rst deasserts, the block stays in IDLE until the first clock edge with start=1; a partially loaded frame is discarded and the next frame reloads from address 0.

Verification
REQ-022 Nominal frame: start pulse, 320 back-to-back samples of value k<<16 -> ram writes to addr 0..319 with wdata k<<16; ac_rst_n low 1 cycle; then startac high 1 cycle; done pulses 1 cycle after doneac rises; err=0.
REQ-023 Gapped input: samp_valid toggling 1/0 -> exactly 320 writes with no duplicates; LOAD lasts 640 cycles.
REQ-024 Second frame with doneac still high from frame 1 -> ENG_CLR clears it; RUN does not exit until the engine reasserts doneac.
REQ-025 Watchdog: TMO=100 with doneac held 0 -> IDLE after 100 RUN cycles; err=1; no done pulse; next start clears err.
REQ-026 Reset mid-LOAD at wcnt=150 -> all outputs at reset values; new frame writes starting at addr 0.
REQ-027 Address mux: in RUN drive ac_addr=0x13F -> ram_addr=0x13F in the same cycle; start pulses during RUN are ignored.

Source files
------------

// File: rtl/ac_frame_seq.sv
// rtl/ac_frame_seq.sv - loads one frame of samples into Sn RAM, then runs the
// autocorrelator engine under a watchdog and reports done/err.
module ac_frame_seq #(
  parameter int N    = 32,
  parameter int NSAM = 320,
  parameter int AW   = 9,
  parameter int TMO  = 65535
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          samp_valid,
  input  logic [N-1:0]  samp_data,
  output logic          samp_ready,
  output logic [AW-1:0] ram_addr,
  output logic [N-1:0]  ram_wdata,
  output logic          ram_wren,
  input  logic [AW-1:0] ac_addr,
  output logic          ac_rst_n,
  output logic          startac,
  input  logic          doneac,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FLUSH,
    S_ENG_CLR,
    S_KICK,
    S_RUN,
    S_FIN
  } state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(NSAM - 1);
  localparam logic [15:0]   WD_LAST  = 16'(TMO - 1);

  state_t        state, state_nx;
  logic [AW-1:0] wcnt;
  logic [AW-1:0] addr_q;
  logic [N-1:0]  wdata_q;
  logic          wren_q;
  logic          ac_rst_q;
  logic          startac_q;
  logic          err_q;
  logic [15:0]   wdog;
  logic          accept;
  logic          last_samp;
  logic          wdog_hit;

  assign accept    = (state == S_LOAD) && samp_valid;
  assign last_samp = accept && (wcnt == LAST_IDX);
  // wdog counts RUN cycles already elapsed, so this fires on the TMO-th RUN cycle
  assign wdog_hit  = (wdog == WD_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    samp_ready = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nx = S_LOAD;
      end
      S_LOAD: begin
        samp_ready = 1'b1;
        if (last_samp) state_nx = S_FLUSH;
      end
      S_FLUSH:   state_nx = S_ENG_CLR;
      S_ENG_CLR: state_nx = S_KICK;
      S_KICK:    state_nx = S_RUN;
      S_RUN: begin
        // doneac has priority over an expiring watchdog in the same cycle
        if (doneac) state_nx = S_FIN;
        else if (wdog_hit) state_nx = S_IDLE;
      end
      S_FIN: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wcnt      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wren_q    <= 1'b0;
      wdog      <= '0;
      err_q     <= 1'b0;
      ac_rst_q  <= 1'b0;
      startac_q <= 1'b0;
    end else begin
      wren_q    <= accept;
      // engine strobes are registered but decoded from the next state so they
      // line up exactly with the ENG_CLR and KICK cycles
      ac_rst_q  <= (state_nx != S_ENG_CLR);
      startac_q <= (state_nx == S_KICK);
      if (state == S_IDLE && start) begin
        wcnt  <= '0;
        err_q <= 1'b0;
      end
      if (accept) begin
        addr_q  <= wcnt;
        wdata_q <= samp_data;
        wcnt    <= wcnt + 1'b1;
      end
      if (state == S_KICK) begin
        wdog <= '0;
      end else if (state == S_RUN) begin
        wdog <= wdog + 16'd1;
      end
      if (state == S_RUN && !doneac && wdog_hit) err_q <= 1'b1;
    end
  end

  assign ram_addr  = (state == S_RUN) ? ac_addr : addr_q;
  assign ram_wdata = wdata_q;
  assign ram_wren  = wren_q;
  assign ac_rst_n  = ac_rst_q;
  assign startac   = startac_q;
  assign err       = err_q;

endmodule
